// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// opcode/funct values, ALU codes, mux selects and trap causes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_RWB, S_MEMADR, S_MEMRD,
    S_LWB, S_MEMWR, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_SLTU  = 3'b111;
  localparam logic [2:0] ALU_UNDEF = 3'b011;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct decoder: maps funct to an ALU operation and flags
// unsupported encodings.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  always_comb begin
    alucontrol    = ALU_UNDEF;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADDU: alucontrol = ALU_ADD;
      FN_SUBU: alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLTU: alucontrol = ALU_SLTU;
      default: funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the shared MIPS-subset datapath: sequences
// fetch/decode/execute/memory/writeback and traps on bad encodings or timeouts.
module mc_controller
  import mc_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        memwrite,
  output logic        iord,
  output logic        irwrite,
  output logic        pcwrite,
  output logic [1:0]  pcsrc,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [2:0]  alucontrol,
  output logic        regwrite,
  output logic [4:0]  destreg,
  output logic        memtoreg,
  output logic        instr_done,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                 trap_q, trap_d;
  logic [1:0]           trap_cause_q, trap_cause_d;

  logic [5:0] op;
  logic [2:0] rtype_alu;
  logic       funct_illegal;
  logic       mem_wait_state;
  logic       mem_timeout;
  logic       unused_instr;

  assign op           = instr[31:26];
  assign unused_instr = ^{instr[25:21], instr[10:6]};

  mc_alu_decoder u_alu_dec (
    .funct         (instr[5:0]),
    .alucontrol    (rtype_alu),
    .funct_illegal (funct_illegal)
  );

  // Memory handshake: mem_req stays high until a cycle where mem_ready is
  // also high; that cycle completes the request. mem_ready is ignored otherwise.
  assign mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                          (state_q == S_MEMWR);
  assign mem_timeout    = (wait_cnt_q == TIMEOUT_W'(TIMEOUT)) && !mem_ready;

  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    mem_req      = 1'b0;
    memwrite     = 1'b0;
    iord         = 1'b0;
    irwrite      = 1'b0;
    pcwrite      = 1'b0;
    pcsrc        = PC_ALU;
    alusrca      = 1'b0;
    alusrcb      = SRCB_RT;
    alucontrol   = ALU_ADD;
    regwrite     = 1'b0;
    destreg      = 5'd0;
    memtoreg     = 1'b0;
    instr_done   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end else if (mem_timeout) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        alusrcb = SRCB_IMM_SL2;
        case (op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDIU:     state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d      = S_TRAP;
            trap_cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
        if (funct_illegal) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_RWB;
        end
      end
      S_RWB: begin
        regwrite   = 1'b1;
        destreg    = instr[15:11];
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = op[3] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_LWB;
        end else if (mem_timeout) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_LWB: begin
        regwrite   = 1'b1;
        destreg    = instr[20:16];
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (mem_timeout) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PC_ALUOUT;
        pcwrite    = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        destreg    = instr[20:16];
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcwrite    = 1'b1;
        pcsrc      = PC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter restarts on every state change so each request gets a full budget.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_wait_state && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
    end
    trap_d = trap_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: the driver pushes the expected control
// word for every cycle it drives; a negedge monitor pops and compares.
module tb_mc_controller;
  import mc_pkg::*;

  localparam int CW = 24;
  typedef logic [CW-1:0] ctl_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic       mem_req, memwrite, iord, irwrite, pcwrite;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       regwrite;
  logic [4:0] destreg;
  logic       memtoreg, instr_done, trap;
  logic [1:0] trap_cause;

  logic [CW-1:0] exp_q[$];
  string         name_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  ctl_t          act;
  ctl_t          mon_e;
  string         mon_nm;

  assign act = {mem_req, memwrite, iord, irwrite, pcwrite, pcsrc, alusrca,
                alusrcb, alucontrol, regwrite, destreg, memtoreg, instr_done,
                trap, trap_cause};

  mc_controller #(.TIMEOUT(4), .TIMEOUT_W(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .regwrite   (regwrite),
    .destreg    (destreg),
    .memtoreg   (memtoreg),
    .instr_done (instr_done),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  // clock / reset
  always #5 clk = ~clk;

  // expected control words, field order matches act
  function automatic ctl_t mk(input logic mreq, input logic mw, input logic io,
                              input logic irw, input logic pcw, input logic [1:0] pcs,
                              input logic asa, input logic [1:0] asb, input logic [2:0] aluc,
                              input logic rw, input logic [4:0] dr, input logic m2r,
                              input logic done, input logic tr, input logic [1:0] tc);
    return {mreq, mw, io, irw, pcw, pcs, asa, asb, aluc, rw, dr, m2r, done, tr, tc};
  endfunction

  function automatic ctl_t e_idle();
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 5'd0, 0, 0, 0, 2'b00);
  endfunction
  function automatic ctl_t e_fetch(input logic rdy);
    return mk(1, 0, 0, rdy, rdy, 2'b00, 0, 2'b01, 3'b010, 0, 5'd0, 0, 0, 0, 2'b00);
  endfunction
  function automatic ctl_t e_decode();
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 5'd0, 0, 0, 0, 2'b00);
  endfunction
  function automatic ctl_t e_exec(input logic [2:0] aluc);
    return mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, aluc, 0, 5'd0, 0, 0, 0, 2'b00);
  endfunction
  function automatic ctl_t e_wb(input logic [4:0] dr, input logic m2r);
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 1, dr, m2r, 1, 0, 2'b00);
  endfunction
  function automatic ctl_t e_imm_alu();
    return mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 5'd0, 0, 0, 0, 2'b00);
  endfunction
  function automatic ctl_t e_memrd();
    return mk(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 5'd0, 0, 0, 0, 2'b00);
  endfunction
  function automatic ctl_t e_memwr(input logic rdy);
    return mk(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 5'd0, 0, rdy, 0, 2'b00);
  endfunction
  function automatic ctl_t e_branch(input logic z);
    return mk(0, 0, 0, 0, z, 2'b01, 1, 2'b00, 3'b110, 0, 5'd0, 0, 1, 0, 2'b00);
  endfunction
  function automatic ctl_t e_jump();
    return mk(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b010, 0, 5'd0, 0, 1, 0, 2'b00);
  endfunction
  function automatic ctl_t e_trap(input logic [1:0] tc);
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 5'd0, 0, 0, 1, tc);
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {opc, 5'd1, rt, imm};
  endfunction

  // driver tasks: called at posedge+1, drive inputs, queue the expected word
  task automatic cyc(input logic rdy, input logic z, input ctl_t e, input string nm);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(1'b0, 1'b0, e_idle(), "reset_hold");
    reset_n = 1'b1;
    cyc(1'b1, 1'b0, e_idle(), "idle_after_release");
  endtask

  task automatic run_rtype(input logic [5:0] fn, input logic [2:0] aluc, input logic [4:0] rd);
    instr = rtype(rd, fn);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "r_fetch");
    cyc(1'b1, 1'b0, e_decode(), "r_decode");
    cyc(1'b1, 1'b0, e_exec(aluc), "r_exec");
    cyc(1'b1, 1'b0, e_wb(rd, 1'b0), "r_rwb");
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      n_checks++;
      if (act === mon_e) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", mon_nm, act, mon_e, $time);
    end
  end

  logic [5:0] fn_tab [5] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101011};
  logic [2:0] al_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
  logic [4:0] rd_tab [5] = '{5'd3, 5'd8, 5'd9, 5'd10, 5'd11};

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // R-type, zero-wait: addu rd=3 first, then the other functs
    for (int i = 0; i < 5; i++) run_rtype(fn_tab[i], al_tab[i], rd_tab[i]);

    // lw rt=5 with three wait cycles in MEMRD
    instr = itype(6'b100011, 5'd5, 16'h0010);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "lw_fetch");
    cyc(1'b1, 1'b0, e_decode(), "lw_decode");
    cyc(1'b1, 1'b0, e_imm_alu(), "lw_memadr");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, e_memrd(), "lw_memrd_wait");
    cyc(1'b1, 1'b0, e_memrd(), "lw_memrd_ready");
    cyc(1'b1, 1'b0, e_wb(5'd5, 1'b1), "lw_lwb");

    // beq taken then not taken
    instr = itype(6'b000100, 5'd2, 16'h0004);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "beq1_fetch");
    cyc(1'b1, 1'b0, e_decode(), "beq1_decode");
    cyc(1'b1, 1'b1, e_branch(1'b1), "beq1_taken");
    cyc(1'b1, 1'b0, e_fetch(1'b1), "beq0_fetch");
    cyc(1'b1, 1'b0, e_decode(), "beq0_decode");
    cyc(1'b1, 1'b0, e_branch(1'b0), "beq0_not_taken");

    // addiu rt=7 with two fetch wait cycles
    instr = itype(6'b001001, 5'd7, 16'h0005);
    cyc(1'b0, 1'b0, e_fetch(1'b0), "addiu_fetch_wait");
    cyc(1'b0, 1'b0, e_fetch(1'b0), "addiu_fetch_wait");
    cyc(1'b1, 1'b0, e_fetch(1'b1), "addiu_fetch");
    cyc(1'b1, 1'b0, e_decode(), "addiu_decode");
    cyc(1'b1, 1'b0, e_imm_alu(), "addiu_ex");
    cyc(1'b1, 1'b0, e_wb(5'd7, 1'b0), "addiu_wb");

    // j
    instr = {6'b000010, 26'h0000010};
    cyc(1'b1, 1'b0, e_fetch(1'b1), "j_fetch");
    cyc(1'b1, 1'b0, e_decode(), "j_decode");
    cyc(1'b1, 1'b0, e_jump(), "j_jump");

    // sw completing exactly when the wait counter reaches TIMEOUT
    instr = itype(6'b101011, 5'd6, 16'h0008);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "sw_fetch");
    cyc(1'b1, 1'b0, e_decode(), "sw_decode");
    cyc(1'b1, 1'b0, e_imm_alu(), "sw_memadr");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, e_memwr(1'b0), "sw_wait");
    cyc(1'b1, 1'b0, e_memwr(1'b1), "sw_late_done");

    // illegal opcode traps and stays trapped
    instr = {6'b111111, 26'h0};
    cyc(1'b1, 1'b0, e_fetch(1'b1), "illop_fetch");
    cyc(1'b1, 1'b0, e_decode(), "illop_decode");
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, e_trap(2'b01), "illop_trap_hold");
    do_reset();

    // illegal funct traps from EXEC
    instr = rtype(5'd4, 6'b000000);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "illfn_fetch");
    cyc(1'b1, 1'b0, e_decode(), "illfn_decode");
    cyc(1'b1, 1'b0, e_exec(3'b011), "illfn_exec");
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, e_trap(2'b01), "illfn_trap_hold");
    do_reset();

    // sw with mem_ready stuck low: five write cycles, then timeout trap
    instr = itype(6'b101011, 5'd6, 16'h0008);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "swto_fetch");
    cyc(1'b1, 1'b0, e_decode(), "swto_decode");
    cyc(1'b1, 1'b0, e_imm_alu(), "swto_memadr");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, e_memwr(1'b0), "swto_wait");
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, e_trap(2'b10), "swto_trap");
    do_reset();

    // reset pulsed during a MEMWR wait, then a clean fetch
    cyc(1'b1, 1'b0, e_fetch(1'b1), "swrst_fetch");
    cyc(1'b1, 1'b0, e_decode(), "swrst_decode");
    cyc(1'b1, 1'b0, e_imm_alu(), "swrst_memadr");
    cyc(1'b0, 1'b0, e_memwr(1'b0), "swrst_wait");
    cyc(1'b0, 1'b0, e_memwr(1'b0), "swrst_wait");
    do_reset();
    instr = {6'b000010, 26'h0000020};
    cyc(1'b0, 1'b0, e_fetch(1'b0), "post_reset_fetch");
    cyc(1'b1, 1'b0, e_fetch(1'b1), "post_reset_fetch_rdy");
    cyc(1'b1, 1'b0, e_decode(), "post_reset_decode");
    cyc(1'b1, 1'b0, e_jump(), "post_reset_jump");

    // final report
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
